// File: rtl/cvp14_mem_pkg.sv
// Shared types and constants for the CVP14 memory-bus responder.
// Imported by the storage array and the control block.
package cvp14_mem_pkg;

    localparam int WORD_W = 16;
    localparam logic [15:0] HALT_ADDR_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE
    } state_t;

endpackage

// File: rtl/dram_responder_mem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Deliberately reset-free so tools can map it onto RAM.
module mem_array
    import cvp14_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dram_responder.sv
// CVP14 memory-bus slave: one word access per request, fixed latency,
// one-cycle Rdy pulse, sticky Halt on HALT_ADDR and Err on RD&WR.
module dram_responder
    import cvp14_mem_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter int          LAT       = 2,
    parameter logic [15:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [15:0]       Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [WORD_W-1:0] DataIn,
    output logic [WORD_W-1:0] DataOut,
    output logic              Rdy,
    output logic              Halt,
    output logic              Err
);

    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_C = CW'(LAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              capture;
    logic [15:0]       cap_addr;
    logic [WORD_W-1:0] cap_data;
    logic              cap_wr;
    logic [WORD_W-1:0] dout_q;
    logic              halt_q;
    logic              err_q;
    logic              done;
    logic              halt_hit;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign done     = (state == DONE);
    assign halt_hit = done && (cap_addr == HALT_ADDR);
    assign mem_we   = done && cap_wr;

    mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk   (Clk1),
        .we    (mem_we),
        .addr  (cap_addr[ADDR_BITS-1:0]),
        .wdata (cap_data),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (RD || WR) begin
                    capture = 1'b1;
                    if (LAT == 0) begin
                        state_n = DONE;
                    end else begin
                        cnt_n   = LAT_C;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - ONE_C;
                if (cnt == ONE_C) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = RELEASE;
            end
            RELEASE: begin
                if (!RD && !WR) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_wr   <= 1'b0;
            dout_q   <= '0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                cap_addr <= Addr;
                cap_data <= DataIn;
                // RD and WR together resolve to a write
                cap_wr   <= WR;
                if (RD && WR) begin
                    err_q <= 1'b1;
                end
            end
            if (done && !cap_wr) begin
                dout_q <= mem_rdata;
            end
            if (halt_hit) begin
                halt_q <= 1'b1;
            end
        end
    end

    // read data and Halt become visible within the DONE cycle itself
    assign DataOut = (done && !cap_wr) ? mem_rdata : dout_q;
    assign Rdy     = done;
    assign Halt    = halt_q | halt_hit;
    assign Err     = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: LAT=2 instance plus a LAT=0 instance.
// Expected values are hand-computed constants.
module tb_dram_responder;

    logic        clk;
    logic        rst_n;

    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        rdy;
    logic        halt;
    logic        err;

    logic [15:0] addr0;
    logic        rd0;
    logic        wr0;
    logic [15:0] din0;
    logic [15:0] dout0;
    logic        rdy0;
    logic        halt0;
    logic        err0;

    int n_chk;
    int n_pass;

    dram_responder #(
        .ADDR_BITS(10),
        .LAT(2),
        .HALT_ADDR(16'hFFFF)
    ) dut (
        .Clk1    (clk),
        .Reset   (rst_n),
        .Addr    (addr),
        .RD      (rd),
        .WR      (wr),
        .DataIn  (din),
        .DataOut (dout),
        .Rdy     (rdy),
        .Halt    (halt),
        .Err     (err)
    );

    dram_responder #(
        .ADDR_BITS(10),
        .LAT(0),
        .HALT_ADDR(16'hFFFF)
    ) dut0 (
        .Clk1    (clk),
        .Reset   (rst_n),
        .Addr    (addr0),
        .RD      (rd0),
        .WR      (wr0),
        .DataIn  (din0),
        .DataOut (dout0),
        .Rdy     (rdy0),
        .Halt    (halt0),
        .Err     (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one request, holds it until Rdy, then drops it and lets
    // the responder return to IDLE. n = edges from capture to Rdy.
    task automatic access(input logic w, input logic r,
                          input logic [15:0] a, input logic [15:0] d,
                          output int n, output logic [15:0] q,
                          output logic h);
        @(negedge clk);
        wr  = w;
        rd  = r;
        addr = a;
        din = d;
        n   = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        q = dout;
        h = halt;
        if (!rdy) n = -1;
        @(negedge clk);
        rd  = 1'b0;
        wr  = 1'b0;
        addr = 16'h7777;
        din = 16'h0BAD;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [15:0] q;
        logic        h;

        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        addr = '0; rd = 0; wr = 0; din = '0;
        addr0 = '0; rd0 = 0; wr0 = 0; din0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_halt", halt, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // known value at 5, then an aborted write over it
        access(1, 0, 16'h0005, 16'h5555, n, q, h);
        chk("wr5_lat", n, 3);
        access(0, 1, 16'h0005, 16'h0000, n, q, h);
        chk("rd5_data", q, 16'h5555);

        @(negedge clk);
        wr = 1; addr = 16'h0005; din = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        wr = 0; addr = 16'h7777;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", rdy, 1'b0);
        chk("abort_dout", dout, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1, 16'h0005, 16'h0000, n, q, h);
        chk("abort_rd5_lat", n, 3);
        chk("abort_rd5", q, 16'h5555);

        access(1, 0, 16'h0010, 16'hBEEF, n, q, h);
        chk("wr10_lat", n, 3);
        chk("wr10_dout_hold", q, 16'h5555);
        access(0, 1, 16'h0010, 16'h0000, n, q, h);
        chk("rd10_lat", n, 3);
        chk("rd10_data", q, 16'hBEEF);
        @(negedge clk);
        chk("dout_idle_hold", dout, 16'hBEEF);

        // LAT=0: hold RD across Rdy
        @(negedge clk);
        rd0 = 1; addr0 = 16'h0001;
        @(posedge clk);
        #1;
        chk("lat0_first", rdy0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rdy0) pulses++;
        end
        chk("lat0_no_repeat", pulses, 0);
        @(negedge clk);
        rd0 = 0;
        @(posedge clk);
        #1;
        chk("lat0_drop", rdy0, 1'b0);
        @(negedge clk);
        rd0 = 1;
        @(posedge clk);
        #1;
        chk("lat0_second", rdy0, 1'b1);
        @(negedge clk);
        rd0 = 0;

        access(1, 0, 16'h0403, 16'h1234, n, q, h);
        access(0, 1, 16'h0003, 16'h0000, n, q, h);
        chk("alias_data", q, 16'h1234);
        chk("alias_halt", h, 1'b0);

        chk("err_before", err, 1'b0);
        access(1, 1, 16'h0020, 16'h00AA, n, q, h);
        chk("both_dout_hold", q, 16'h1234);
        chk("err_set", err, 1'b1);
        access(0, 1, 16'h0020, 16'h0000, n, q, h);
        chk("both_as_write", q, 16'h00AA);

        access(1, 0, 16'h03FF, 16'hC0DE, n, q, h);
        chk("halt_before", halt, 1'b0);
        access(0, 1, 16'hFFFF, 16'h0000, n, q, h);
        chk("halt_done", h, 1'b1);
        chk("halt_alias", q, 16'hC0DE);
        access(0, 1, 16'h0010, 16'h0000, n, q, h);
        chk("halt_sticky", halt, 1'b1);
        chk("after_halt_rd", q, 16'hBEEF);
        chk("err_sticky", err, 1'b1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_halt", halt, 1'b0);
        chk("rst2_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
